// File: rtl/pp_pipeline_pkg.sv
// Shared definitions for the pre-processing pipeline stages: FSM state encoding,
// default counter width and the AXI4-Stream keep-width helper.
package pp_pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } packerState_t;

  localparam int DEFAULT_DIM_WIDTH = 16;

  function automatic int keepWidth(input int pack, input int dataWidth);
    return pack * dataWidth / 8;
  endfunction

endpackage

// File: rtl/pp_axis_out_reg.sv
// AXI4-Stream output register: holds its payload stable while valid is stalled by the sink.
module pp_axis_out_reg #(
  parameter int PAYLOAD_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_load,
  input  logic [PAYLOAD_WIDTH-1:0] i_payload,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [PAYLOAD_WIDTH-1:0] o_payload,
  output logic                     o_free
);

  logic                     r_valid;
  logic [PAYLOAD_WIDTH-1:0] r_payload;

  assign o_free    = !r_valid || i_ready;
  assign o_valid   = r_valid;
  assign o_payload = r_payload;

  // The producer only loads when o_free, so a load never overwrites an unaccepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_payload <= i_payload;
    end else if (i_ready) begin
      r_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/pp_fifo_to_axis_packer.sv
// Drains a FWFT FIFO and packs PACK tokens per AXI4-Stream beat, one rows x cols frame per start.
// Optional start-of-frame m_tuser output is enabled by defining PP_PACKER_TUSER_EN.
module pp_fifo_to_axis_packer
  import pp_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int DIM_WIDTH  = DEFAULT_DIM_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   i_start,
  input  logic [DIM_WIDTH-1:0]                   i_cols,
  input  logic [DIM_WIDTH-1:0]                   i_rows,
  output logic                                   o_busy,
  output logic                                   o_done,
  input  logic                                   i_in_empty_n,
  output logic                                   o_in_read,
  input  logic [DATA_WIDTH-1:0]                  i_in_dout,
  output logic [DATA_WIDTH*PACK-1:0]             o_m_tdata,
  output logic [keepWidth(PACK, DATA_WIDTH)-1:0] o_m_tkeep,
  output logic                                   o_m_tvalid,
  input  logic                                   i_m_tready,
`ifdef PP_PACKER_TUSER_EN
  output logic                                   o_m_tlast,
  output logic                                   o_m_tuser
`else
  output logic                                   o_m_tlast
`endif
);

  localparam int KEEP_W         = keepWidth(PACK, DATA_WIDTH);
  localparam int BYTES_PER_LANE = DATA_WIDTH / 8;
  localparam int BEAT_W         = DATA_WIDTH * PACK;
  localparam int LANE_W         = (PACK > 1) ? $clog2(PACK) : 1;
`ifdef PP_PACKER_TUSER_EN
  localparam int USER_W         = 1;
`else
  localparam int USER_W         = 0;
`endif
  localparam int PAY_W          = BEAT_W + KEEP_W + 1 + USER_W;

  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(PACK - 1);
  localparam logic [DIM_WIDTH-1:0] DIM_ONE   = DIM_WIDTH'(1);

  packerState_t         r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_allRead;
  logic [DIM_WIDTH-1:0] r_cols;
  logic [DIM_WIDTH-1:0] r_rows;
  logic [DIM_WIDTH-1:0] r_col;
  logic [DIM_WIDTH-1:0] r_row;
  logic [LANE_W-1:0]    r_lane;
  logic [BEAT_W-1:0]    r_acc;
`ifdef PP_PACKER_TUSER_EN
  logic                 r_firstBeat;
`endif

  logic              w_outFree;
  logic              w_valid;
  logic              w_colLast;
  logic              w_rowLast;
  logic              w_closing;
  logic              w_read;
  logic [BEAT_W-1:0] w_beatData;
  logic [KEEP_W-1:0] w_beatKeep;
  logic [PAY_W-1:0]  w_payIn;
  logic [PAY_W-1:0]  w_payOut;

  assign w_colLast = (r_col == r_cols - DIM_ONE);
  assign w_rowLast = (r_row == r_rows - DIM_ONE);
  assign w_closing = (r_lane == LAST_LANE) || w_colLast;
  // r_allRead stops reads once the frame's final token is in, while its beat drains.
  assign w_read    = (r_state == RUN) && !r_allRead && i_in_empty_n && (!w_closing || w_outFree);

  assign o_in_read  = w_read;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_m_tvalid = w_valid;

  // Lanes above r_lane are always zero in r_acc, so only the current lane is patched in.
  always_comb begin
    w_beatData = r_acc;
    w_beatKeep = '0;
    for (int k = 0; k < PACK; k++) begin
      if (LANE_W'(k) == r_lane) w_beatData[k*DATA_WIDTH +: DATA_WIDTH] = i_in_dout;
      if (LANE_W'(k) <= r_lane) w_beatKeep[k*BYTES_PER_LANE +: BYTES_PER_LANE] = '1;
    end
  end

`ifdef PP_PACKER_TUSER_EN
  assign w_payIn = {r_firstBeat, w_colLast, w_beatKeep, w_beatData};
  assign {o_m_tuser, o_m_tlast, o_m_tkeep, o_m_tdata} = w_payOut;
`else
  assign w_payIn = {w_colLast, w_beatKeep, w_beatData};
  assign {o_m_tlast, o_m_tkeep, o_m_tdata} = w_payOut;
`endif

  pp_axis_out_reg #(
    .PAYLOAD_WIDTH(PAY_W)
  ) u_outReg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_read && w_closing),
    .i_payload(w_payIn),
    .i_ready  (i_m_tready),
    .o_valid  (w_valid),
    .o_payload(w_payOut),
    .o_free   (w_outFree)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_allRead   <= 1'b0;
      r_cols      <= '0;
      r_rows      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_lane      <= '0;
      r_acc       <= '0;
`ifdef PP_PACKER_TUSER_EN
      r_firstBeat <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cols      <= i_cols;
            r_rows      <= i_rows;
            r_col       <= '0;
            r_row       <= '0;
            r_lane      <= '0;
            r_acc       <= '0;
            r_allRead   <= 1'b0;
            r_busy      <= 1'b1;
`ifdef PP_PACKER_TUSER_EN
            r_firstBeat <= 1'b1;
`endif
            if (i_cols == '0 || i_rows == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_read) begin
            if (w_closing) begin
              r_acc       <= '0;
              r_lane      <= '0;
`ifdef PP_PACKER_TUSER_EN
              r_firstBeat <= 1'b0;
`endif
            end else begin
              for (int k = 0; k < PACK; k++) begin
                if (LANE_W'(k) == r_lane) r_acc[k*DATA_WIDTH +: DATA_WIDTH] <= i_in_dout;
              end
              r_lane <= r_lane + LANE_W'(1);
            end
            if (w_colLast) begin
              r_col <= '0;
              if (w_rowLast) r_allRead <= 1'b1;
              else           r_row     <= r_row + DIM_ONE;
            end else begin
              r_col <= r_col + DIM_ONE;
            end
          end
          if (r_allRead && w_valid && i_m_tready) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_fifo_to_axis_packer.sv
// Self-checking bench for pp_fifo_to_axis_packer: FIFO/sink models with random pacing,
// expected beats computed per row by chunking tokens into groups of PACK.
module tb_pp_fifo_to_axis_packer;

  localparam int DW      = 8;
  localparam int PACK    = 4;
  localparam int DIMW    = 16;
  localparam int KB      = DW / 8;
  localparam int KW      = PACK * KB;
  localparam int BEAT_W  = DW * PACK;
  localparam int MAX_CYC = 3000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_start = 1'b0;
  logic [DIMW-1:0]   i_cols = '0;
  logic [DIMW-1:0]   i_rows = '0;
  logic              o_busy;
  logic              o_done;
  logic              i_in_empty_n = 1'b0;
  logic              o_in_read;
  logic [DW-1:0]     i_in_dout = '0;
  logic [BEAT_W-1:0] o_m_tdata;
  logic [KW-1:0]     o_m_tkeep;
  logic              o_m_tvalid;
  logic              i_m_tready = 1'b1;
  logic              o_m_tlast;
`ifdef PP_PACKER_TUSER_EN
  logic              o_m_tuser;
`endif

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [KW-1:0]     keep;
    logic              last;
    logic              user;
  } beat_t;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] tokQ[$];
  int            tokIdx = 0;
  beat_t         expQ[$];
  beat_t         gotQ[$];

  always #5 clk = ~clk;

  pp_fifo_to_axis_packer #(
    .DATA_WIDTH(DW),
    .PACK      (PACK),
    .DIM_WIDTH (DIMW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_cols      (i_cols),
    .i_rows      (i_rows),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_in_empty_n(i_in_empty_n),
    .o_in_read   (o_in_read),
    .i_in_dout   (i_in_dout),
    .o_m_tdata   (o_m_tdata),
    .o_m_tkeep   (o_m_tkeep),
    .o_m_tvalid  (o_m_tvalid),
    .i_m_tready  (i_m_tready),
`ifdef PP_PACKER_TUSER_EN
    .o_m_tlast   (o_m_tlast),
    .o_m_tuser   (o_m_tuser)
`else
    .o_m_tlast   (o_m_tlast)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic beat_t curBeat();
    beat_t b;
    b.data = o_m_tdata;
    b.keep = o_m_tkeep;
    b.last = o_m_tlast;
`ifdef PP_PACKER_TUSER_EN
    b.user = o_m_tuser;
`else
    b.user = 1'b0;
`endif
    return b;
  endfunction

  task automatic fillSeq(input int base, input int n);
    tokQ.delete();
    for (int i = 0; i < n; i++) tokQ.push_back(DW'(base + i));
  endtask

  task automatic fillRand(input int n);
    tokQ.delete();
    for (int i = 0; i < n; i++) tokQ.push_back(DW'($urandom));
  endtask

  // Each row is split into ceil(cols/PACK) beats; the last beat of a row carries tlast.
  task automatic buildExpected(input int cols, input int rows);
    expQ.delete();
    for (int r = 0; r < rows; r++) begin
      for (int c0 = 0; c0 < cols; c0 += PACK) begin
        beat_t b;
        b = '0;
        for (int l = 0; l < PACK; l++) begin
          if (c0 + l < cols) begin
            b.data[l*DW +: DW] = tokQ[r*cols + c0 + l];
            b.keep[l*KB +: KB] = {KB{1'b1}};
          end
        end
        b.last = (c0 + PACK >= cols);
        b.user = (r == 0 && c0 == 0);
        expQ.push_back(b);
      end
    end
  endtask

  // Modes: 0 gap-free, 1 empty_n toggling, 2 random empty/ready, 3 ready low for cycles 8..12.
  task automatic applyStimulus(input int mode, input int cyc, input bit popped);
    bit en;
    bit rdy;
    bit avail;
    if (popped) tokIdx++;
    avail = tokIdx < tokQ.size();
    case (mode)
      1:       begin en = (cyc % 2) == 1; rdy = 1'b1; end
      2:       begin en = $urandom_range(0, 3) != 0; rdy = $urandom_range(0, 2) != 0; end
      3:       begin en = 1'b1; rdy = !(cyc >= 8 && cyc <= 12); end
      default: begin en = 1'b1; rdy = 1'b1; end
    endcase
    i_in_empty_n = avail && en;
    i_in_dout    = (avail && en) ? tokQ[tokIdx] : DW'($urandom);
    i_m_tready   = rdy;
  endtask

  task automatic runFrame(input int cols, input int rows, input int mode, input bit midStart);
    int    cyc;
    int    lastHs;
    int    doneCyc;
    int    doneCnt;
    int    stallReads;
    int    expDone;
    int    n;
    bit    readNow;
    bit    stalled;
    bit    fin;
    beat_t held;
    buildExpected(cols, rows);
    gotQ.delete();
    tokIdx = 0; cyc = 0; lastHs = -1; doneCyc = -1; doneCnt = 0;
    stallReads = 0; readNow = 1'b0; stalled = 1'b0; fin = 1'b0; held = '0;
    @(posedge clk); #1;
    i_start = 1'b1; i_cols = DIMW'(cols); i_rows = DIMW'(rows);
    applyStimulus(mode, 0, 1'b0);
    while (!fin && cyc < MAX_CYC) begin
      @(negedge clk);
      readNow = o_in_read;
      if (o_in_read) checkOutput("readWhileEmpty", i_in_empty_n, 1);
      if (cyc == 0) checkOutput("busyAtStart", o_busy, 0);
      else if (doneCyc < 0) checkOutput("busyInFrame", o_busy, 1);
      else begin
        checkOutput("busyAfterDone", o_busy, 0);
        checkOutput("donePulseWidth", o_done, 0);
        fin = 1'b1;
      end
      if (stalled) checkOutput("stallHold", curBeat(), held);
      if (o_m_tvalid && !i_m_tready) begin
        if (!stalled) stallReads = 0;
        if (readNow) stallReads++;
        checkOutput("stallExtraReads", stallReads <= PACK - 1, 1);
        held = curBeat();
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (o_m_tvalid && i_m_tready) begin
        gotQ.push_back(curBeat());
        lastHs = cyc;
      end
      if (o_done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      i_start = midStart && cyc == 1;
      if (i_start) begin i_cols = DIMW'(1); i_rows = DIMW'(1); end
      applyStimulus(mode, cyc, readNow);
    end
    checkOutput("frameTimeout", fin, 1);
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("tokensRead", tokIdx, cols * rows);
    checkOutput("beatCount", gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput("beatData", gotQ[i].data, expQ[i].data);
      checkOutput("beatKeep", gotQ[i].keep, expQ[i].keep);
      checkOutput("beatLast", gotQ[i].last, expQ[i].last);
`ifdef PP_PACKER_TUSER_EN
      checkOutput("beatUser", gotQ[i].user, expQ[i].user);
`endif
    end
    expDone = (expQ.size() == 0) ? 1 : lastHs + 1;
    checkOutput("doneTiming", doneCyc, expDone);
  endtask

  initial begin
    int  nReads;
    bit  rd;
    int  rc;
    int  rr;

    $display("[TB] reset check");
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", o_busy, 0);
    checkOutput("rstDone", o_done, 0);
    checkOutput("rstRead", o_in_read, 0);
    checkOutput("rstValid", o_m_tvalid, 0);
    checkOutput("rstData", o_m_tdata, 0);
    checkOutput("rstKeep", o_m_tkeep, 0);
    checkOutput("rstLast", o_m_tlast, 0);
`ifdef PP_PACKER_TUSER_EN
    checkOutput("rstUser", o_m_tuser, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] 8x2 gap-free frame");
    fillSeq(8'h01, 16);
    runFrame(8, 2, 0, 1'b0);
    if (gotQ.size() == 4) begin
      checkOutput("ex1Beat0", gotQ[0].data, 32'h04030201);
      checkOutput("ex1Beat1", gotQ[1].data, 32'h08070605);
      checkOutput("ex1Beat1Last", gotQ[1].last, 1);
      checkOutput("ex1Beat3", gotQ[3].data, 32'h100F0E0D);
    end

    $display("[TB] 6x1 partial beat");
    fillSeq(8'hA0, 6);
    runFrame(6, 1, 0, 1'b0);
    if (gotQ.size() == 2) begin
      checkOutput("ex2Beat0Keep", gotQ[0].keep, 4'hF);
      checkOutput("ex2Beat1Data", gotQ[1].data, 32'h0000A5A4);
      checkOutput("ex2Beat1Keep", gotQ[1].keep, 4'h3);
      checkOutput("ex2Beat1Last", gotQ[1].last, 1);
    end

    $display("[TB] backpressure window");
    fillRand(24);
    runFrame(8, 3, 3, 1'b0);

    $display("[TB] empty_n toggling");
    fillSeq(8'h01, 16);
    runFrame(8, 2, 1, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 5; f++) begin
      rc = $urandom_range(1, 13);
      rr = $urandom_range(1, 3);
      fillRand(rc * rr);
      runFrame(rc, rr, 2, f == 2);
    end

    $display("[TB] empty frames");
    fillRand(5);
    runFrame(5, 0, 0, 1'b1);
    fillRand(5);
    runFrame(0, 3, 0, 1'b0);

    $display("[TB] reset mid-frame");
    fillRand(8);
    tokIdx = 0;
    nReads = 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_cols = DIMW'(8); i_rows = DIMW'(1);
    applyStimulus(0, 0, 1'b0);
    for (int c = 0; c < 40 && nReads < 3; c++) begin
      @(negedge clk);
      rd = o_in_read;
      if (rd) nReads++;
      @(posedge clk); #1;
      i_start = 1'b0;
      applyStimulus(0, c + 1, rd);
    end
    checkOutput("preResetReads", nReads, 3);
    reset = 1'b1;
    i_in_empty_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRstValid", o_m_tvalid, 0);
    checkOutput("midRstBusy", o_busy, 0);
    checkOutput("midRstRead", o_in_read, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    fillSeq(8'h40, 16);
    runFrame(8, 2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pp_fifo_to_axis_packer.md
# pp_fifo_to_axis_packer

Downstream consumer stage of the pre-processing pipeline's inter-stage FIFOs. It drains DATA_WIDTH-bit tokens from a first-word-fall-through FIFO read port (empty_n/read/dout) and packs PACK tokens per beat into an AXI4-Stream master. It generates TKEEP for partial beats and TLAST at every row end, for a frame of runtime-programmed rows × cols tokens. It runs one frame per start pulse and reports completion with a done pulse.

## Interface
- DATA_WIDTH, 8: token width in bits.
- PACK, 4: tokens per output beat; power of two, ≥1.
- DIM_WIDTH, 16: width of cols/rows inputs and internal counters.
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; latches cols/rows and begins a frame when idle.
- cols  in  DIM_WIDTH  tokens per row, sampled at start.
- rows  in  DIM_WIDTH  rows per frame, sampled at start.
- busy  out  1  high from the accepted start until the done cycle inclusive.
- done  out  1  one-cycle pulse when the frame completes.
- in_empty_n  in  1  FIFO has data; in_dout is valid whenever it is high.
- in_read  out  1  pops one token this cycle.
- in_dout  in  DATA_WIDTH  FIFO head token.
- m_tdata  out  DATA_WIDTH*PACK  packed beat; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH], lane 0 holds the earliest token.
- m_tkeep  out  PACK*DATA_WIDTH/8  byte enables for filled lanes (DATA_WIDTH multiple of 8).
- m_tvalid  out  1  beat valid.
- m_tready  in  1  sink ready.
- m_tlast  out  1  last beat of a row.
- m_tuser  out  1  start-of-frame; present only with PP_PACKER_TUSER_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN: start=1 with cols≠0 and rows≠0. This latches the dimensions and clears col, row and lane counters.
- IDLE → DONE: start=1 with cols=0 or rows=0. No FIFO reads occur.
- start is ignored outside IDLE.
- RUN: in_read = in_empty_n & (not beat-closing token | out_free), where out_free = !m_tvalid | m_tready.
  - A token is beat-closing when lane==PACK-1 or col==cols-1.
  - in_read is never high outside RUN.
- On each read:
  - The token is written into accumulator lane `lane`.
  - Non-closing token: lane++ and col++.
  - Closing token: the accumulator plus this token loads the output register. Unfilled lanes are zero with keep=0. tlast=(col==cols-1). lane resets to 0.
  - At col==cols-1: col resets to 0 and row increments.
- The output register holds tdata/tkeep/tlast/tuser stable while m_tvalid & !m_tready.
- Handshake m_tvalid & m_tready on the frame's final beat (last row, tlast) → DONE.
- DONE: done=1 for one cycle, then → IDLE.
- Counters are DIM_WIDTH bits with no wrap. col max = cols-1, row max = rows-1.
- Reset, including mid-frame: state IDLE, m_tvalid=0, counters and accumulator cleared, partial beat discarded. The FIFO is not flushed.

## Timing
- Reset values: busy=0, done=0, in_read=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, m_tuser=0.
- Latency: a closing token read at cycle t appears as m_tvalid at t+1.
- Throughput: 1 token/cycle sustained when in_empty_n=1 and m_tready=1.
- Backpressure: non-closing tokens are still read while the output is stalled. The closing token waits until out_free.
- busy rises the cycle after start. done is high in the cycle after the final handshake. busy falls after done.

## Configuration
- PP_PACKER_TUSER_EN defined:
  - m_tuser exists.
  - It is 1 on the first beat of each frame, 0 otherwise.
  - It is held with the beat.
- Undefined: the m_tuser port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package pp_pipeline_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default DIM_WIDTH constant;
  - the keep-width function PACK*DATA_WIDTH/8.
- Sub-module pp_axis_out_reg is the output register with valid/ready hold logic, parameterised by payload width. The FSM and counters stay in the top module.

## Test plan
- cols=8, rows=2, PACK=4, tokens 0x01..0x10, tready=1 → 4 beats: 0x04030201, 0x08070605 tlast, 0x0C0B0A09, 0x100F0E0D tlast. keep=0xF on all beats. done one cycle after the 4th beat.
- cols=6, rows=1, tokens 0xA0..0xA5 → beats 0xA3A2A1A0 keep=0xF tlast=0, then 0x0000A5A4 keep=0x3 tlast=1.
- tready low for 5 cycles mid-frame → at most 3 extra tokens read, tdata/tkeep/tlast unchanged while stalled, no token lost or duplicated.
- in_empty_n toggling every cycle → in_read only when in_empty_n=1, output sequence identical to the gap-free run.
- start with rows=0 → no in_read, done at the cycle after start, m_tvalid stays 0. A second start while busy is ignored.
- reset asserted after 3 tokens of a cols=8 frame → m_tvalid=0 and busy=0 next cycle. A new start then produces a clean frame. With PP_PACKER_TUSER_EN, tuser=1 on the first beat only.
